// File: rtl/demux_lanes_param_cond.sv
// demux_lanes_param_cond: registered per-lane 1:M demux, slot from external select or per-lane round-robin pointer
module demux_lanes_param_cond #(
    parameter  int DATA_W = 8,
    parameter  int N_IN   = 2,
    parameter  int M      = 2,
    localparam int SEL_W  = $clog2(M)
) (
    input  logic                       clk_2f,
    input  logic                       reset,
    input  logic                       auto_mode,
    input  logic [SEL_W-1:0]           sel_in,
    input  logic [N_IN-1:0]            valid_in,
    input  logic [N_IN*DATA_W-1:0]     data_in,
    output logic [N_IN*M-1:0]          valid_out,
    output logic [N_IN*M*DATA_W-1:0]   data_out,
    output logic [N_IN*SEL_W-1:0]      ptr_out
);
    logic [N_IN-1:0][SEL_W-1:0]    r_ptr;
    logic [N_IN-1:0][SEL_W-1:0]    w_sel;
    logic [N_IN*M-1:0]             r_valid;
    logic [N_IN*M-1:0][DATA_W-1:0] r_data;
    always_comb begin
        for (int i = 0; i < N_IN; i++) w_sel[i] = auto_mode ? r_ptr[i] : sel_in;
    end
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_ptr   <= '0;
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                for (int k = 0; k < M; k++) r_valid[i*M+k] <= valid_in[i] && (w_sel[i] == SEL_W'(k));
                if (valid_in[i]) r_data[i*M+int'(w_sel[i])] <= data_in[i*DATA_W +: DATA_W];
                r_ptr[i] <= auto_mode ? r_ptr[i] + SEL_W'(valid_in[i]) : sel_in;
            end
        end
    end
    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign ptr_out   = r_ptr;
endmodule

// File: doc/demux_lanes_param_cond.md
Name: demux_lanes_param_cond

Overview:
- Parametrised successor of the 2-lane, 1:2, 8-bit conditional demux used in the PHY datapath.
- Distributes each of N_IN input lanes across M output slots.
- Slot selection per lane is either:
  - driven by an external selector, or
  - taken from an internal round-robin pointer that advances on every valid word.
- All outputs are registered, one clock after input; sits between the lane-split stage and the per-slot FIFOs.

Parameters:
- DATA_W, 8, width of each data word.
- N_IN, 2, number of independent input lanes.
- M, 2, output slots per lane; power of two, M >= 2.
- SEL_W, $clog2(M), selector/pointer width; derived, not overridden.

Ports:
- clk_2f  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- auto_mode  input  1  1 = per-lane internal round-robin pointer; 0 = external sel_in.
- sel_in  input  SEL_W  external slot select, shared by all lanes when auto_mode=0.
- valid_in  input  N_IN  bit i qualifies lane i word.
- data_in  input  N_IN*DATA_W  lane i word at [i*DATA_W +: DATA_W].
- valid_out  output  N_IN*M  bit i*M+k = lane i, slot k valid.
- data_out  output  N_IN*M*DATA_W  lane i slot k word at [(i*M+k)*DATA_W +: DATA_W].
- ptr_out  output  N_IN*SEL_W  current pointer of lane i at [i*SEL_W +: SEL_W].

Interface decision: one clock (clk_2f); reset is synchronous and active-high (reset).

Behaviour:
- Reset: sampled on the clk_2f edge, dominant over all other inputs. Result: valid_out=0, data_out=0, all pointers=0.
- Reset asserted mid-stream: the word presented in that cycle is discarded. The first post-reset word goes to slot 0 in auto mode.
- Per lane i, each non-reset edge:
  - Slot select: s = auto_mode ? ptr[i] : sel_in.
  - valid_out[i*M+k] <= valid_in[i] && (k == s), for every k.
  - If valid_in[i]=1: slot s data register <= lane i word.
  - All other slot data registers of lane i hold their previous value. Data is not cleared when valid drops.
- Latency: exactly 1 cycle from valid_in/data_in to valid_out/data_out. No backpressure; one word per lane per cycle accepted unconditionally.
- Pointer update, auto_mode=1:
  - If valid_in[i]=1: ptr[i] <= ptr[i]+1, wrapping M-1 -> 0 via natural SEL_W overflow.
  - If valid_in[i]=0: ptr[i] holds.
- Pointer update, auto_mode=0: ptr[i] <= sel_in every cycle, regardless of valid.
  - A switch 0->1 therefore starts round-robin from the last sampled sel_in.
  - A switch 1->0 takes effect on the same edge: that cycle's word uses sel_in.
- Lanes are fully independent in auto mode; each pointer advances only on its own valid.
- ptr_out is a direct view of the pointer registers. After an accepting edge it shows the slot the next valid word will use.
- At most one valid_out bit per lane is high in any cycle; never more.
- With N_IN=2, M=2, auto_mode=0, behaviour equals the previous fixed 2-lane 1:2 demux with registered outputs and active-high sync reset.

Test Plan:
- Reset: reset=1 for 2 cycles with valid_in=2'b11, data_in=16'hBBAA -> valid_out=0, data_out=0, ptr_out=0; after release, first words land in slot 0 of each lane.
- External select (N_IN=2, M=2): auto_mode=0, sel_in=1, valid_in=2'b11, data_in={8'h22,8'h11}.
  - Next cycle: valid_out=4'b1010, slot1 lane0=8'h11, slot1 lane1=8'h22; slot0 data unchanged.
  - Then sel_in=0 -> valid_out=4'b0101.
- Round-robin wrap (M=4, N_IN=1): auto_mode=1, five consecutive valid words 01..05 -> slots 0,1,2,3,0 on successive cycles; ptr_out sequence 1,2,3,0,1; slot0 data finally 8'h05.
- Independent lanes with gaps: auto_mode=1, lane0 valid every cycle, lane1 valid every other cycle -> lane1 pointer advances only on its valid cycles; valid_out lane1 low on gap cycles and its data holds.
- Mode switch: auto_mode=0 with sel_in=1 for one cycle, then auto_mode=1 with three valid words -> slots 1,0,1 (M=2); switching back to auto_mode=0, sel_in=0 routes the next word to slot 0 that same cycle.
- Mid-stream reset: reset asserted for 1 cycle while a word is valid and ptr=2 (M=4) -> that word is not output, ptr_out=0, next valid word appears in slot 0.
